// File: rtl/mem_bus_bridge_pkg.sv
// Shared definitions for the MEM-stage bus bridge: FSM state encodings, access size
// codes and the alignment/address helpers also used by loadselect/storeselect.
package mem_bus_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Size code 11 is illegal and behaves exactly like a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = lsb[0];
            default: is_misaligned = (lsb != 2'b00);
        endcase
    endfunction

    function automatic logic [31:0] bus_address(input logic [1:0] size, input logic [31:0] addr);
        if (size == SZ_BYTE || size == SZ_HALF)
            bus_address = addr;
        else
            bus_address = {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_bus_bridge_watchdog.sv
// Saturating transaction-age counter with a sticky timeout flag; only reset clears the flag.
module mem_bus_bridge_watchdog #(
    parameter int WAIT_MAX = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam int CW = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_MAX);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count   <= '0;
            timeout <= 1'b0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != CNT_MAX) begin
            count <= count + 1'b1;
            if (count == CNT_MAX - 1'b1)
                timeout <= 1'b1;
        end
    end

endmodule

// File: rtl/mem_bus_bridge.sv
// MEM-stage data-memory bridge: one pipeline load/store becomes one split
// addr_ok/data_ok bus transaction, stalling the pipeline until the response returns.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | no transaction; launches a request for a legal cpu_en access
//  ST_REQ   | bus_req asserted, fields frozen, waiting for addr_ok
//  ST_WAIT  | request accepted, waiting for data_ok
//  ST_DONE  | response taken, pipeline advances this cycle
//  ST_DRAIN | flushed after acceptance; swallow the orphan data_ok
module mem_bus_bridge
    import mem_bus_bridge_pkg::*;
#(
    parameter int WAIT_MAX = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_en,
    input  logic [3:0]  cpu_wen,
    input  logic [1:0]  cpu_size,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        flush_i,
    output logic [31:0] cpu_rdata,
    output logic        stall_o,
    output logic        addr_err,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,
    output logic        bus_timeout
);

    state_t state;
    logic   misaligned;
    logic   launch;
    logic   wd_enable;

    assign misaligned = is_misaligned(cpu_size, cpu_addr[1:0]);
    assign addr_err   = (state == ST_IDLE) && cpu_en && misaligned;
    assign launch     = (state == ST_IDLE) && cpu_en && !flush_i && !misaligned;
    assign wd_enable  = (state == ST_REQ) || (state == ST_WAIT) || (state == ST_DRAIN);

    always_comb begin
        stall_o = 1'b0;
        case (state)
            ST_IDLE:  stall_o = launch;
            ST_REQ:   stall_o = 1'b1;
            ST_WAIT:  stall_o = 1'b1;
            ST_DONE:  stall_o = 1'b0;
            // The killed access no longer owns MEM; only a new instruction there must wait.
            ST_DRAIN: stall_o = cpu_en;
            default:  stall_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            bus_req   <= 1'b0;
            bus_wr    <= 1'b0;
            bus_size  <= 2'b00;
            bus_addr  <= '0;
            bus_wdata <= '0;
            cpu_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        bus_req   <= 1'b1;
                        bus_wr    <= |cpu_wen;
                        bus_size  <= cpu_size;
                        bus_addr  <= bus_address(cpu_size, cpu_addr);
                        bus_wdata <= cpu_wdata;
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (flush_i && !bus_addr_ok) begin
                        bus_req <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (bus_addr_ok) begin
                        bus_req <= 1'b0;
                        if (bus_data_ok) begin
                            if (!bus_wr)
                                cpu_rdata <= bus_rdata;
                            state <= ST_DONE;
                        end else begin
                            state <= flush_i ? ST_DRAIN : ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus_data_ok) begin
                        if (!bus_wr)
                            cpu_rdata <= bus_rdata;
                        state <= ST_DONE;
                    end else if (flush_i) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                ST_DRAIN: begin
                    if (bus_data_ok)
                        state <= ST_IDLE;
                end
                default: begin
                    bus_req <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    mem_bus_bridge_watchdog #(
        .WAIT_MAX (WAIT_MAX)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (launch),
        .enable  (wd_enable),
        .timeout (bus_timeout)
    );

endmodule
